// File: rtl/id_ex_pipeline_register.sv
// ID/EX boundary register: latches decode-stage control and operands, resolves the EX destination,
// detects load-use hazards against EX, injects bubbles on hazard/flush and counts them (saturating).
module id_ex_pipeline_register #(
    parameter int CW_W   = 22,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CW_W-1:0]   id_ctrl,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_rs_val,
    input  logic [DATA_W-1:0] id_rt_val,
    input  logic [15:0]       id_imm16,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic              flush,
    input  logic              ex_hold,
    output logic              hazard_stall,
    output logic [CW_W-1:0]   ex_ctrl,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_rs_val,
    output logic [DATA_W-1:0] ex_rt_val,
    output logic [15:0]       ex_imm16,
    output logic [4:0]        ex_dest,
    output logic              ex_valid,
    output logic [CNT_W-1:0]  bubble_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    logic [CW_W-1:0]   ex_ctrl_r;
    logic [DATA_W-1:0] ex_pc_r;
    logic [DATA_W-1:0] ex_rs_val_r;
    logic [DATA_W-1:0] ex_rt_val_r;
    logic [15:0]       ex_imm16_r;
    logic [4:0]        ex_dest_r;
    logic              ex_valid_r;
    logic [CNT_W-1:0]  bubble_cnt_r;

    logic [CW_W-1:0]   ctrl_clean_s;
    logic [4:0]        dest_next_s;
    logic              hazard_s;
    logic              load_s;
    logic              bubble_s;

    // Unknown control bits collapse to a NOP so X never reaches EX.
    always_comb begin
        ctrl_clean_s = id_ctrl;
        if ((^id_ctrl) === 1'bx) begin
            ctrl_clean_s = {CW_W{1'b0}};
        end else begin
            ctrl_clean_s = id_ctrl;
        end
    end

    // Destination: link register for JAL-type, rt for immediate forms, rd otherwise.
    always_comb begin
        dest_next_s = id_rd;
        if (ctrl_clean_s[20]) begin
            dest_next_s = 5'd31;
        end else if (ctrl_clean_s[17]) begin
            dest_next_s = id_rt;
        end else begin
            dest_next_s = id_rd;
        end
    end

    // Load-use detection; the rt compare is deliberately conservative for every class.
    always_comb begin
        hazard_s = 1'b0;
        if (ex_valid_r && ex_ctrl_r[10] && ex_ctrl_r[9] && (ex_dest_r != 5'd0) &&
            ((ex_dest_r == id_rs) || (ex_dest_r == id_rt))) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = 1'b0;
        end
    end

    // Update priority: flush, then hold, then hazard bubble, then normal load.
    always_comb begin
        load_s   = 1'b0;
        bubble_s = 1'b0;
        if (flush) begin
            bubble_s = 1'b1;
        end else if (ex_hold) begin
            bubble_s = 1'b0;
        end else if (hazard_s) begin
            bubble_s = 1'b1;
        end else begin
            load_s = 1'b1;
        end
    end

    assign hazard_stall = hazard_s;

    // Control word and valid flag: bubbles clear them, loads take the ID instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl_r  <= {CW_W{1'b0}};
            ex_valid_r <= 1'b0;
        end else if (bubble_s) begin
            ex_ctrl_r  <= {CW_W{1'b0}};
            ex_valid_r <= 1'b0;
        end else if (load_s) begin
            ex_ctrl_r  <= ctrl_clean_s;
            ex_valid_r <= (ctrl_clean_s != {CW_W{1'b0}});
        end else begin
            ex_ctrl_r  <= ex_ctrl_r;
            ex_valid_r <= ex_valid_r;
        end
    end

    // Data fields only move on a normal load; bubbles leave them as don't-care (held).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_pc_r     <= {DATA_W{1'b0}};
            ex_rs_val_r <= {DATA_W{1'b0}};
            ex_rt_val_r <= {DATA_W{1'b0}};
            ex_imm16_r  <= 16'h0000;
            ex_dest_r   <= 5'd0;
        end else if (load_s) begin
            ex_pc_r     <= id_pc;
            ex_rs_val_r <= id_rs_val;
            ex_rt_val_r <= id_rt_val;
            ex_imm16_r  <= id_imm16;
            ex_dest_r   <= dest_next_s;
        end else begin
            ex_pc_r     <= ex_pc_r;
            ex_rs_val_r <= ex_rs_val_r;
            ex_rt_val_r <= ex_rt_val_r;
            ex_imm16_r  <= ex_imm16_r;
            ex_dest_r   <= ex_dest_r;
        end
    end

    // Saturating bubble counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_r <= {CNT_W{1'b0}};
        end else if (bubble_s) begin
            bubble_cnt_r <= sat_inc(bubble_cnt_r);
        end else begin
            bubble_cnt_r <= bubble_cnt_r;
        end
    end

    assign ex_ctrl      = ex_ctrl_r;
    assign ex_pc        = ex_pc_r;
    assign ex_rs_val    = ex_rs_val_r;
    assign ex_rt_val    = ex_rt_val_r;
    assign ex_imm16     = ex_imm16_r;
    assign ex_dest      = ex_dest_r;
    assign ex_valid     = ex_valid_r;
    assign bubble_count = bubble_cnt_r;

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Directed, table-driven bench for id_ex_pipeline_register plus hand-written reset,
// mid-operation reset and counter saturation sequences.
module tb_id_ex_pipeline_register;

    logic        clk;
    logic        rst_n;
    logic [21:0] id_ctrl;
    logic [31:0] id_pc, id_rs_val, id_rt_val;
    logic [15:0] id_imm16;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        flush, ex_hold;
    logic        hazard_stall;
    logic [21:0] ex_ctrl;
    logic [31:0] ex_pc, ex_rs_val, ex_rt_val;
    logic [15:0] ex_imm16;
    logic [4:0]  ex_dest;
    logic        ex_valid;
    logic [15:0] bubble_count;

    int compared = 0;
    int mismatched = 0;

    id_ex_pipeline_register dut (
        .clk(clk), .rst_n(rst_n), .id_ctrl(id_ctrl), .id_pc(id_pc),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm16(id_imm16),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush), .ex_hold(ex_hold),
        .hazard_stall(hazard_stall), .ex_ctrl(ex_ctrl), .ex_pc(ex_pc),
        .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val), .ex_imm16(ex_imm16),
        .ex_dest(ex_dest), .ex_valid(ex_valid), .bubble_count(bubble_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [21:0] ctrl;
        logic [4:0]  rs, rt, rd;
        logic [31:0] pc;
        logic        fl, hd;
        logic        exp_stall;
        logic [21:0] exp_ctrl;
        logic [4:0]  exp_dest;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(logic [21:0] c, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                logic [31:0] pc, logic fl, logic hd, logic es, logic [21:0] ec,
                                logic [4:0] ed, logic ev, logic [31:0] ep, logic [15:0] en);
        vec_t v;
        v.ctrl = c; v.rs = rs; v.rt = rt; v.rd = rd; v.pc = pc; v.fl = fl; v.hd = hd;
        v.exp_stall = es; v.exp_ctrl = ec; v.exp_dest = ed; v.exp_valid = ev;
        v.exp_pc = ep; v.exp_cnt = en;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [21:0] c, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] pc, input logic fl,
                         input logic hd);
        id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd; id_pc = pc;
        id_rs_val = pc ^ 32'h5555_0000;
        id_rt_val = pc + 32'd7;
        id_imm16  = pc[15:0] + 16'h0001;
        flush = fl; ex_hold = hd;
    endtask

    initial begin
        // Stimulus table; data operands are derived from pc, so expected data follows exp_pc.
        tbl[0]  = mk(22'h013200, 5'd1,  5'd5,  5'd5, 32'h100, 1'b0, 1'b0, 1'b0, 22'h013200, 5'd5,  1'b1, 32'h100, 16'd0);
        tbl[1]  = mk(22'h033200, 5'd1,  5'd7,  5'd9, 32'h104, 1'b0, 1'b0, 1'b0, 22'h033200, 5'd7,  1'b1, 32'h104, 16'd0);
        tbl[2]  = mk(22'h010200, 5'd1,  5'd7,  5'd9, 32'h108, 1'b0, 1'b0, 1'b0, 22'h010200, 5'd9,  1'b1, 32'h108, 16'd0);
        tbl[3]  = mk(22'h100000, 5'd0,  5'd0,  5'd0, 32'h10C, 1'b0, 1'b0, 1'b0, 22'h100000, 5'd31, 1'b1, 32'h10C, 16'd0);
        tbl[4]  = mk(22'h010200, 5'd1,  5'd2,  5'd3, 32'h110, 1'b1, 1'b0, 1'b0, 22'h000000, 5'd31, 1'b0, 32'h10C, 16'd1);
        tbl[5]  = mk(22'h020600, 5'd1,  5'd8,  5'd3, 32'h114, 1'b0, 1'b0, 1'b0, 22'h020600, 5'd8,  1'b1, 32'h114, 16'd1);
        tbl[6]  = mk(22'h000201, 5'd8,  5'd2,  5'd4, 32'h118, 1'b0, 1'b0, 1'b1, 22'h000000, 5'd8,  1'b0, 32'h114, 16'd2);
        tbl[7]  = mk(22'h000201, 5'd8,  5'd2,  5'd4, 32'h118, 1'b0, 1'b0, 1'b0, 22'h000201, 5'd4,  1'b1, 32'h118, 16'd2);
        tbl[8]  = mk(22'h020600, 5'd1,  5'd6,  5'd3, 32'h11C, 1'b0, 1'b0, 1'b0, 22'h020600, 5'd6,  1'b1, 32'h11C, 16'd2);
        tbl[9]  = mk(22'h000000, 5'd0,  5'd6,  5'd0, 32'h120, 1'b0, 1'b0, 1'b1, 22'h000000, 5'd6,  1'b0, 32'h11C, 16'd3);
        tbl[10] = mk(22'h000000, 5'd0,  5'd6,  5'd0, 32'h120, 1'b0, 1'b0, 1'b0, 22'h000000, 5'd0,  1'b0, 32'h120, 16'd3);
        tbl[11] = mk(22'h020600, 5'd0,  5'd0,  5'd2, 32'h124, 1'b0, 1'b0, 1'b0, 22'h020600, 5'd0,  1'b1, 32'h124, 16'd3);
        tbl[12] = mk(22'h010200, 5'd0,  5'd0,  5'd5, 32'h128, 1'b0, 1'b0, 1'b0, 22'h010200, 5'd5,  1'b1, 32'h128, 16'd3);
        tbl[13] = mk(22'h020600, 5'd1,  5'd12, 5'd3, 32'h12C, 1'b0, 1'b0, 1'b0, 22'h020600, 5'd12, 1'b1, 32'h12C, 16'd3);
        tbl[14] = mk(22'h000201, 5'd12, 5'd1,  5'd1, 32'h130, 1'b0, 1'b1, 1'b1, 22'h020600, 5'd12, 1'b1, 32'h12C, 16'd3);
        tbl[15] = mk(22'h010200, 5'd3,  5'd12, 5'd2, 32'h134, 1'b0, 1'b1, 1'b1, 22'h020600, 5'd12, 1'b1, 32'h12C, 16'd3);
        tbl[16] = mk(22'h010200, 5'd1,  5'd2,  5'd3, 32'h138, 1'b0, 1'b1, 1'b0, 22'h020600, 5'd12, 1'b1, 32'h12C, 16'd3);
        tbl[17] = mk(22'h010200, 5'd12, 5'd2,  5'd3, 32'h13C, 1'b1, 1'b1, 1'b1, 22'h000000, 5'd12, 1'b0, 32'h12C, 16'd4);
        tbl[18] = mk(22'h010200, 5'd12, 5'd2,  5'd3, 32'h140, 1'b0, 1'b0, 1'b0, 22'h010200, 5'd3,  1'b1, 32'h140, 16'd4);

        // Reset with arbitrary inputs: everything must read zero.
        rst_n = 1'b0;
        drive(22'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ex_ctrl", 32'(ex_ctrl), 32'h0);
        chk("rst_ex_valid", 32'(ex_valid), 32'h0);
        chk("rst_ex_pc", ex_pc, 32'h0);
        chk("rst_ex_rs_val", ex_rs_val, 32'h0);
        chk("rst_ex_dest", 32'(ex_dest), 32'h0);
        chk("rst_bubble_count", 32'(bubble_count), 32'h0);
        chk("rst_hazard_stall", 32'(hazard_stall), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            drive(tbl[i].ctrl, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].pc, tbl[i].fl, tbl[i].hd);
            #1;
            chk($sformatf("v%0d_hazard_stall", i), 32'(hazard_stall), 32'(tbl[i].exp_stall));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ex_ctrl", i), 32'(ex_ctrl), 32'(tbl[i].exp_ctrl));
            chk($sformatf("v%0d_ex_dest", i), 32'(ex_dest), 32'(tbl[i].exp_dest));
            chk($sformatf("v%0d_ex_valid", i), 32'(ex_valid), 32'(tbl[i].exp_valid));
            chk($sformatf("v%0d_ex_pc", i), ex_pc, tbl[i].exp_pc);
            chk($sformatf("v%0d_ex_rs_val", i), ex_rs_val, tbl[i].exp_pc ^ 32'h5555_0000);
            chk($sformatf("v%0d_ex_rt_val", i), ex_rt_val, tbl[i].exp_pc + 32'd7);
            chk($sformatf("v%0d_ex_imm16", i), 32'(ex_imm16), 32'(tbl[i].exp_pc[15:0] + 16'h0001));
            chk($sformatf("v%0d_bubble_count", i), 32'(bubble_count), 32'(tbl[i].exp_cnt));
        end

        // Asynchronous reset mid-cycle clears EX without waiting for an edge.
        @(negedge clk);
        drive(22'h020600, 5'd1, 5'd9, 5'd2, 32'h200, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ex_ctrl", 32'(ex_ctrl), 32'h0);
        chk("midrst_ex_valid", 32'(ex_valid), 32'h0);
        chk("midrst_ex_pc", ex_pc, 32'h0);
        chk("midrst_bubble_count", 32'(bubble_count), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_first_load", 32'(ex_ctrl), 32'h020600);
        chk("post_rst_first_dest", 32'(ex_dest), 32'd9);

        // Saturation: count up to FFFE with flushes, then three more must pin at FFFF.
        @(negedge clk);
        drive(22'h010200, 5'd1, 5'd2, 5'd3, 32'h300, 1'b1, 1'b0);
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_fffe", 32'(bubble_count), 32'h0000_FFFE);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("sat_bubble_%0d", k), 32'(bubble_count), 32'h0000_FFFF);
        end
        chk("sat_ex_valid", 32'(ex_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
